register_bank: RTL



---
 rtl/register_bank_pkg.sv | 12 +
 rtl/register_bank_if.sv | 27 ++
 rtl/register_bank.sv | 47 ++++
 3 files changed

// File: rtl/register_bank_pkg.sv
// Shared datapath constants and types for the register file, ALU, shifter and decode.
package register_bank_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned LINK_REG = 31;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/register_bank_if.sv
// Read/write port bundle of the register file; the datapath drives the master side.
interface register_bank_if #(
  parameter int unsigned DATA_W = register_bank_pkg::DATA_W,
  parameter int unsigned ADDR_W = register_bank_pkg::ADDR_W
);

  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              link_en;
  logic [DATA_W-1:0] link_data;

  modport master (
    output rs, rt, wr_en, wr_addr, wr_data, link_en, link_data,
    input  rs_data, rt_data
  );

  modport slave (
    input  rs, rt, wr_en, wr_addr, wr_data, link_en, link_data,
    output rs_data, rt_data
  );

endinterface

// File: rtl/register_bank.sv
// 32-entry register file: two combinational read ports, one general write port,
// and a link write port for jump-and-link. Register 0 reads as zero.
module register_bank #(
  parameter int unsigned DATA_W   = register_bank_pkg::DATA_W,
  parameter int unsigned ADDR_W   = register_bank_pkg::ADDR_W,
  parameter int unsigned LINK_REG = register_bank_pkg::LINK_REG
) (
  input logic             clk,
  input logic             rst,
  register_bank_if.slave  bus
);

  import register_bank_pkg::ZERO_REG;

  localparam int unsigned       NREG     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] r_regs [0:NREG-1];

  logic w_gen_we;
  logic w_link_we;

  assign w_gen_we  = bus.wr_en   && (bus.wr_addr != ZERO_IDX);
  assign w_link_we = bus.link_en && (LINK_IDX    != ZERO_IDX);

  // The link write is issued last so it overrides a general write to the same index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_gen_we) begin
        r_regs[bus.wr_addr] <= bus.wr_data;
      end
      if (w_link_we) begin
        r_regs[LINK_IDX] <= bus.link_data;
      end
    end
  end

  // No write bypass: wr_data is derived from these outputs in the datapath.
  assign bus.rs_data = (bus.rs == ZERO_IDX) ? '0 : r_regs[bus.rs];
  assign bus.rt_data = (bus.rt == ZERO_IDX) ? '0 : r_regs[bus.rt];

endmodule
